// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the instruction decoder side (master) and the
// hazard/stall controller (slave) of the 5-stage RV32I pipeline.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwen;
    logic              ex_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwen;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwen;
    logic              ex_pcsel;
    logic              dmem_req;
    logic              dmem_ready;

    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              ex_mem_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mem_wb_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_err;
    logic [15:0]       stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_regwen, ex_is_load,
        output mem_rd, mem_regwen, wb_rd, wb_regwen,
        output ex_pcsel, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
        input  if_id_flush, id_ex_flush, mem_wb_bubble,
        input  fwd_a, fwd_b, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_regwen, ex_is_load,
        input  mem_rd, mem_regwen, wb_rd, wb_regwen,
        input  ex_pcsel, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
        output if_id_flush, id_ex_flush, mem_wb_bubble,
        output fwd_a, fwd_b, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: stage enables, flushes, EX forwarding selects,
// data-memory wait sequencing with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_e;

    state_e            r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [15:0]       r_stall_cycles;

    logic w_memwait;
    logic w_loaduse;
    logic w_freeze;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_id_ex_en;
    logic w_ex_mem_en;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_mem_wb_bubble;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd
    );
        if (mem_we && mem_rd != '0 && mem_rd == rs)
            return 2'b01;
        else if (wb_we && wb_rd != '0 && wb_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_memwait = bus.dmem_req & ~bus.dmem_ready;

    assign w_loaduse = bus.ex_is_load & bus.ex_regwen & (bus.ex_rd != '0) &
                       ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                        (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // Entry into a wait (from RUN) and every not-ready MEM_WAIT cycle freeze alike.
    assign w_freeze = ((r_state == ST_RUN) & w_memwait) |
                      ((r_state == ST_MEM_WAIT) & ~bus.dmem_ready);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // branches below leaves a signal unassigned (which would infer a latch).
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_id_ex_en      = 1'b1;
        w_ex_mem_en     = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;

        if (r_state == ST_ERROR || w_freeze) begin
            w_pc_en         = 1'b0;
            w_if_id_en      = 1'b0;
            w_id_ex_en      = 1'b0;
            w_ex_mem_en     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (bus.ex_pcsel) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_loaduse) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in this
    // block samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_wcnt         <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (!w_pc_en && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;

            case (r_state)
                ST_RUN: begin
                    if (w_memwait) begin
                        r_state <= ST_MEM_WAIT;
                        r_wcnt  <= WCNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        r_state <= ST_RUN;
                        r_wcnt  <= '0;
                    end else if (r_wcnt == WCNT_W'(MEM_TIMEOUT)) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_ERROR;
            endcase
        end
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.id_ex_en      = w_id_ex_en;
    assign bus.ex_mem_en     = w_ex_mem_en;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_flush   = w_id_ex_flush;
    assign bus.mem_wb_bubble = w_mem_wb_bubble;
    assign bus.mem_err       = (r_state == ST_ERROR);
    assign bus.stall_cycles  = r_stall_cycles;

    assign bus.fwd_a = fwd_sel(bus.ex_rs1, bus.mem_regwen, bus.mem_rd,
                               bus.wb_regwen, bus.wb_rd);
    assign bus.fwd_b = fwd_sel(bus.ex_rs2, bus.mem_regwen, bus.mem_rd,
                               bus.wb_regwen, bus.wb_rd);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control words are queued
// as each step is driven and popped/compared on the following falling edge.
module tb_pipeline_hazard_ctrl;
    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 15;

    typedef struct {
        string       tag;
        logic [12:0] ctl;
        logic [15:0] stall;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

    pipeline_hazard_ctrl #(
        .REG_AW     (REG_AW),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {pc,if_id,id_ex,ex_mem enables, if_id/id_ex flush, bubble, fwd_a, fwd_b, mem_err}
    function automatic logic [12:0] mk(input logic [3:0] en, input logic [1:0] fl,
                                       input logic bub, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic err);
        return {en, fl, bub, fa, fb, err};
    endfunction

    localparam logic [12:0] CTL_RUN = {4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [12:0] CTL_FRZ = {4'b0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0};
    localparam logic [12:0] CTL_ERR = {4'b0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1};
    localparam logic [12:0] CTL_BR  = {4'b1111, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = '0;  bus.ex_rs2 = '0;  bus.ex_rd = '0;
        bus.ex_regwen = 1'b0; bus.ex_is_load = 1'b0;
        bus.mem_rd = '0;  bus.mem_regwen = 1'b0;
        bus.wb_rd = '0;   bus.wb_regwen = 1'b0;
        bus.ex_pcsel = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    task automatic step(input string tag, input logic [12:0] ctl, input logic [15:0] st);
        exp_t e;
        logic [12:0] obs;
        exp_q.push_back('{tag, ctl, st});
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
               bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble,
               bus.fwd_a, bus.fwd_b, bus.mem_err};
        check({e.tag, "/ctl"}, 32'(obs), 32'(e.ctl));
        check({e.tag, "/stall"}, 32'(bus.stall_cycles), 32'(e.stall));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset_idle", CTL_RUN, 16'd0);

        // Load-use on rs2: one bubble, then the load result comes from MEM/WB.
        bus.ex_is_load = 1'b1; bus.ex_regwen = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
        step("loaduse", mk(4'b0011, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0), 16'd0);
        idle();
        bus.ex_rd = 5'd5; bus.ex_regwen = 1'b1; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
        bus.ex_rs2 = 5'd5; bus.wb_rd = 5'd5; bus.wb_regwen = 1'b1;
        step("loaduse_fwd", mk(4'b1111, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0), 16'd1);

        // x0 destination and an unused source never stall.
        idle();
        bus.ex_is_load = 1'b1; bus.ex_regwen = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1'b1;
        step("loaduse_x0", CTL_RUN, 16'd1);
        bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b0;
        step("loaduse_unused", CTL_RUN, 16'd1);

        // Forwarding priority and x0 suppression.
        idle();
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd7;
        bus.mem_regwen = 1'b1; bus.wb_regwen = 1'b1;
        step("fwd_prio", mk(4'b1111, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0), 16'd1);
        bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rs1 = 5'd0;
        step("fwd_x0", CTL_RUN, 16'd1);
        bus.mem_rd = 5'd3; bus.wb_rd = 5'd4; bus.ex_rs1 = 5'd4; bus.ex_rs2 = 5'd3;
        step("fwd_mix", mk(4'b1111, 2'b00, 1'b0, 2'b10, 2'b01, 1'b0), 16'd1);

        // Branch resolved alongside a load-use hazard: flush only.
        idle();
        bus.ex_pcsel = 1'b1; bus.ex_is_load = 1'b1; bus.ex_regwen = 1'b1;
        bus.ex_rd = 5'd6; bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1;
        step("branch_lu", CTL_BR, 16'd1);
        idle();
        step("post_branch", CTL_RUN, 16'd1);

        // Three-cycle memory wait; a branch seen while frozen is ignored until release.
        bus.dmem_req = 1'b1;
        step("mw0", CTL_FRZ, 16'd1);
        bus.ex_pcsel = 1'b1;
        step("mw1", CTL_FRZ, 16'd2);
        step("mw2", CTL_FRZ, 16'd3);
        bus.dmem_ready = 1'b1;
        step("mw_release", CTL_BR, 16'd4);
        idle();
        step("mw_run", CTL_RUN, 16'd4);

        // Reset while waiting returns to RUN.
        bus.dmem_req = 1'b1;
        step("mw_rst0", CTL_FRZ, 16'd4);
        step("mw_rst1", CTL_FRZ, 16'd5);
        pulse_reset();
        idle();
        step("mw_rst_run", CTL_RUN, 16'd0);

        // Timeout: MEM_TIMEOUT+1 not-ready cycles, then sticky ERROR.
        bus.dmem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++)
            step($sformatf("tmo_wait%0d", i), CTL_FRZ, 16'(i));
        idle();
        bus.mem_rd = 5'd2; bus.mem_regwen = 1'b1; bus.ex_rs1 = 5'd2;
        step("tmo_err_fwd", mk(4'b0000, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1), 16'd16);
        idle();
        bus.dmem_ready = 1'b1;
        step("tmo_err_hold", CTL_ERR, 16'd17);
        pulse_reset();
        idle();
        step("tmo_rst", CTL_RUN, 16'd0);

        // Saturation: sit in ERROR past 65535 stall cycles.
        bus.dmem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++)
            step($sformatf("sat_wait%0d", i), CTL_FRZ, 16'(i));
        idle();
        step("sat_err", CTL_ERR, 16'd16);
        repeat (65517) @(posedge clk);
        #1;
        step("sat_fffe", CTL_ERR, 16'hFFFE);
        step("sat_ffff", CTL_ERR, 16'hFFFF);
        repeat (5000) @(posedge clk);
        #1;
        step("sat_hold", CTL_ERR, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
